// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Purpose  : Posted-write FIFO between core data port and handshaked memory,
//            with youngest-match load forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic          empty,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [AW-1:0]      r_addr [DEPTH];
  logic [DW-1:0]      r_data [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic          w_full;
  logic          w_enq;
  logic          w_deq;
  logic          w_hit;
  logic [DW-1:0] w_fwd;

  assign w_full   = (r_count == c_CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign stall    = memwrite & w_full;
  assign w_enq    = memwrite & ~w_full;
  assign wr_valid = ~empty;
  assign w_deq    = wr_valid & wr_ready;
  assign wr_addr  = r_addr[r_head];
  assign wr_data  = r_data[r_head];
  assign rd_addr  = dataadr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_tail] <= dataadr;
        r_data[r_tail] <= writedata;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins; the head entry still
  // forwards in the cycle it drains.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [c_PTR_W-1:0] idx;
      idx = r_head + c_PTR_W'(k);
      if ((c_CNT_W'(k) < r_count) &&
          (r_addr[idx][AW-1:2] == dataadr[AW-1:2])) begin
        w_hit = 1'b1;
        w_fwd = r_data[idx];
      end
    end
  end

  assign readdata = (!memwrite && w_hit) ? w_fwd : rd_data;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Directed self-checking bench for store_buffer (DEPTH=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        empty;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] q[$];
  logic        prev_hold;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;
  logic        prev_stall;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .empty     (empty),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    rd_data = '0; wr_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // Basic drain
    memwrite = 1'b1; dataadr = 32'h10; writedata = 32'h11111111;
    #1 check("bd_stall", {31'd0, stall}, 32'd0);
    tick();
    memwrite = 1'b0;
    #1;
    check("bd_wr_valid", {31'd0, wr_valid}, 32'd1);
    check("bd_wr_addr", wr_addr, 32'h10);
    check("bd_wr_data", wr_data, 32'h11111111);
    check("bd_empty", {31'd0, empty}, 32'd0);
    wr_ready = 1'b1;
    tick();
    check("bd_empty_after", {31'd0, empty}, 32'd1);
    check("bd_valid_after", {31'd0, wr_valid}, 32'd0);
    wr_ready = 1'b0;

    // Full / stall
    store(32'h0, 32'h100);
    store(32'h4, 32'h104);
    store(32'h8, 32'h108);
    store(32'hC, 32'h10C);
    memwrite = 1'b1; dataadr = 32'h20; writedata = 32'h120;
    #1 check("fs_stall_full", {31'd0, stall}, 32'd1);
    tick();
    check("fs_stall_hold", {31'd0, stall}, 32'd1);
    check("fs_head", wr_addr, 32'h0);
    wr_ready = 1'b1;
    #1 check("fs_stall_deq", {31'd0, stall}, 32'd1);
    tick();
    wr_ready = 1'b0;
    #1;
    check("fs_stall_drop", {31'd0, stall}, 32'd0);
    check("fs_head2", wr_addr, 32'h4);
    tick();
    dataadr = 32'h99;
    #1 check("fs_full_again", {31'd0, stall}, 32'd1);
    memwrite = 1'b0;
    wr_ready = 1'b1;
    #1 check("fs_drain0", wr_addr, 32'h4);
    tick();
    check("fs_drain1", wr_addr, 32'h8);
    tick();
    check("fs_drain2", wr_addr, 32'hC);
    tick();
    check("fs_drain3", wr_addr, 32'h20);
    check("fs_drain3_data", wr_data, 32'h120);
    tick();
    check("fs_empty", {31'd0, empty}, 32'd1);
    wr_ready = 1'b0;

    // Forwarding youngest
    store(32'h40, 32'hAAAA0001);
    store(32'h40, 32'hBBBB0002);
    dataadr = 32'h42; rd_data = 32'h12345678;
    #1 check("fw_youngest", readdata, 32'hBBBB0002);
    dataadr = 32'h44; rd_data = 32'hDEAD0000;
    #1;
    check("fw_miss", readdata, 32'hDEAD0000);
    check("fw_rd_addr", rd_addr, 32'h44);
    memwrite = 1'b1; dataadr = 32'h40; rd_data = 32'h55;
    #1 check("fw_store_cycle", readdata, 32'h55);
    memwrite = 1'b0;
    wr_ready = 1'b1;
    tick();
    #1 check("fw_draining", readdata, 32'hBBBB0002);
    tick();
    #1 check("fw_after_drain", readdata, 32'h55);
    check("fw_empty", {31'd0, empty}, 32'd1);
    wr_ready = 1'b0;

    // Simultaneous enqueue/dequeue across pointer wrap
    store(32'h200, 32'hD0);
    store(32'h204, 32'hD1);
    wr_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      memwrite = 1'b1; dataadr = 32'h200 + 32'(4 * i); writedata = 32'hD0 + 32'(i);
      #1;
      check("se_stall", {31'd0, stall}, 32'd0);
      check("se_order", wr_addr, 32'h200 + 32'(4 * (i - 2)));
      tick();
    end
    memwrite = 1'b0;
    #1 check("se_tail0", wr_addr, 32'h220);
    tick();
    check("se_tail1", wr_data, 32'hD9);
    tick();
    check("se_empty", {31'd0, empty}, 32'd1);

    // Random handshake with scoreboard
    prev_hold = 1'b0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    for (int c = 0; c < 200; c++) begin
      if (!prev_stall) begin
        memwrite  = 1'($urandom_range(0, 1));
        dataadr   = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        writedata = $urandom;
      end
      wr_ready = 1'($urandom_range(0, 1));
      #1;
      check("rnd_valid", {31'd0, wr_valid}, {31'd0, q.size() != 0});
      if (wr_valid && q.size() != 0) begin
        check("rnd_addr", wr_addr, q[0][63:32]);
        check("rnd_data", wr_data, q[0][31:0]);
      end
      if (prev_hold) begin
        check("rnd_hold_addr", wr_addr, prev_addr);
        check("rnd_hold_data", wr_data, prev_data);
      end
      check("rnd_stall", {31'd0, stall}, {31'd0, memwrite && q.size() == 4});
      prev_hold  = wr_valid & ~wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      prev_stall = memwrite & (q.size() == 4);
      if (wr_valid && wr_ready && q.size() != 0) void'(q.pop_front());
      if (memwrite && !prev_stall) q.push_back({dataadr, writedata});
      tick();
    end
    memwrite = 1'b0;
    wr_ready = 1'b1;
    for (int c = 0; c < 10 && !empty; c++) tick();
    check("rnd_flush_empty", {31'd0, empty}, 32'd1);
    wr_ready = 1'b0;

    // Reset mid-operation
    store(32'h300, 32'hA0);
    store(32'h304, 32'hA1);
    store(32'h308, 32'hA2);
    check("rm_pending", {31'd0, wr_valid}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("rm_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rm_empty", {31'd0, empty}, 32'd1);
    check("rm_wr_addr", wr_addr, 32'd0);
    dataadr = 32'h304; rd_data = 32'hCAFE0000;
    #1 check("rm_load", readdata, 32'hCAFE0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
